// File: rtl/compute_engine_mac_pipe.sv
// Signed multiply-accumulate engine: pipelined products summed into VEC_LEN-term
// dot products, emitted saturated to OUT_W bits on a registered valid/ready output.
module compute_engine_mac_pipe #(
  parameter int A_W        = 16,
  parameter int B_W        = 8,
  parameter int MUL_STAGES = 3,
  parameter int VEC_LEN    = 16,
  parameter int OUT_W      = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [A_W-1:0]             in_a,
  input  logic [B_W-1:0]             in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic                       out_ovf,
  output logic [$clog2(VEC_LEN)-1:0] term_idx
);

  localparam int P_W   = A_W + B_W;
  localparam int IDX_W = $clog2(VEC_LEN);
  localparam int ACC_W = P_W + IDX_W;

  logic adv;
  logic accept;

  // A held result freezes the whole pipeline; nothing moves until it is taken.
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv && !reset;
  assign accept   = in_valid && in_ready;

  logic signed [A_W-1:0] a_reg;
  logic signed [B_W-1:0] b_reg;
  logic                  s1_valid_reg;
  logic                  s1_last_reg;
  logic [IDX_W-1:0]      term_idx_reg;
  logic                  idx_last;

  assign idx_last = (term_idx_reg == IDX_W'(VEC_LEN - 1));
  assign term_idx = term_idx_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg        <= '0;
      b_reg        <= '0;
      s1_valid_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
      term_idx_reg <= '0;
    end else if (adv) begin
      s1_valid_reg <= accept;
      if (accept) begin
        a_reg        <= $signed(in_a);
        b_reg        <= $signed(in_b);
        s1_last_reg  <= idx_last;
        term_idx_reg <= idx_last ? '0 : term_idx_reg + 1'b1;
      end
    end
  end

  for (genvar gi = 2; gi <= MUL_STAGES; gi++) begin : g_stage
    logic signed [P_W-1:0] prod_reg;
    logic                  valid_reg;
    logic                  last_reg;

    if (gi == 2) begin : g_mul
      always_ff @(posedge clk) begin
        if (reset) begin
          prod_reg  <= '0;
          valid_reg <= 1'b0;
          last_reg  <= 1'b0;
        end else if (adv) begin
          prod_reg  <= P_W'(a_reg) * P_W'(b_reg);
          valid_reg <= s1_valid_reg;
          last_reg  <= s1_last_reg;
        end
      end
    end else begin : g_shift
      always_ff @(posedge clk) begin
        if (reset) begin
          prod_reg  <= '0;
          valid_reg <= 1'b0;
          last_reg  <= 1'b0;
        end else if (adv) begin
          prod_reg  <= g_stage[gi-1].prod_reg;
          valid_reg <= g_stage[gi-1].valid_reg;
          last_reg  <= g_stage[gi-1].last_reg;
        end
      end
    end
  end

  logic signed [P_W-1:0]   fin_prod;
  logic                    fin_valid;
  logic                    fin_last;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W-1:0] acc_next;
  logic                    first_reg;
  logic [ACC_W-OUT_W:0]    upper;
  logic                    ovf_next;
  logic [OUT_W-1:0]        sat_next;

  assign fin_prod  = g_stage[MUL_STAGES].prod_reg;
  assign fin_valid = g_stage[MUL_STAGES].valid_reg;
  assign fin_last  = g_stage[MUL_STAGES].last_reg;

  assign prod_ext = ACC_W'(fin_prod);
  assign acc_next = first_reg ? prod_ext : acc_reg + prod_ext;

  // The value fits OUT_W bits only when every bit from OUT_W-1 up matches the sign.
  assign upper    = acc_next[ACC_W-1:OUT_W-1];
  assign ovf_next = !((&upper) || !(|upper));

  always_comb begin
    sat_next = acc_next[OUT_W-1:0];
    if (ovf_next) begin
      sat_next = acc_next[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                   : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg   <= '0;
      first_reg <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (adv) begin
      // adv implies the current result (if any) is being taken this edge.
      out_valid <= fin_valid && fin_last;
      if (fin_valid) begin
        acc_reg   <= acc_next;
        first_reg <= fin_last;
        if (fin_last) begin
          out_data <= sat_next;
          out_ovf  <= ovf_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_compute_engine_mac_pipe.sv
// Randomized self-checking bench for compute_engine_mac_pipe against a
// dot-product reference model (VEC_LEN=4, MUL_STAGES=3, OUT_W=24).
module tb_compute_engine_mac_pipe;
  localparam int A_W = 16;
  localparam int B_W = 8;
  localparam int MUL = 3;
  localparam int VL  = 4;
  localparam int OW  = 24;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [A_W-1:0] in_a = '0;
  logic [B_W-1:0] in_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OW-1:0] out_data;
  logic          out_ovf;
  logic [1:0]    term_idx;

  compute_engine_mac_pipe #(
    .A_W(A_W), .B_W(B_W), .MUL_STAGES(MUL), .VEC_LEN(VL), .OUT_W(OW)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf), .term_idx(term_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int wraps = 0;
  logic [1:0] prev_idx = 2'd0;
  longint exp_sum = 0;
  int exp_cnt = 0;
  logic [OW:0] obs_q[$];
  int obs_cyc_q[$];
  logic [OW:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Collects each result at the moment it is handed over, plus term_idx wraps.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      obs_q.push_back({out_ovf, out_data});
      obs_cyc_q.push_back(cyc);
    end
    if (!reset && prev_idx == 2'd3 && term_idx == 2'd0) wraps <= wraps + 1;
    prev_idx <= term_idx;
  end

  // Reference: plain integer dot product, saturated at the end of each vector.
  task automatic model_accept(input longint p);
    logic signed [63:0] s;
    logic [OW:0] e;
    exp_sum += p;
    exp_cnt++;
    acc_cyc = cyc + 1;
    if (exp_cnt == VL) begin
      s = exp_sum;
      if (exp_sum > 64'sd8388607) e = {1'b1, 24'h7FFFFF};
      else if (exp_sum < -64'sd8388608) e = {1'b1, 24'h800000};
      else e = {1'b0, s[OW-1:0]};
      exp_q.push_back(e);
      exp_sum = 0;
      exp_cnt = 0;
    end
  endtask

  task automatic send(input logic signed [A_W-1:0] a, input logic signed [B_W-1:0] b);
    bit done = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    for (int w = 0; w < 200 && !done; w++) begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(longint'(a) * longint'(b));
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_accept got=timeout required=accepted a=%0d b=%0d", a, b);
    end
  endtask

  task automatic wait_results(input int n, output bit ok);
    ok = 0;
    for (int w = 0; w < 300 && !ok; w++) begin
      @(negedge clk);
      if (obs_q.size() >= n) ok = 1;
    end
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    exp_sum = 0;
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready got=%b required=0", in_ready);
    end
    @(posedge clk);
    #1;
    apply_reset();
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, term_idx, out_data, out_ovf} !== {1'b0, 1'b1, 2'd0, 24'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got=v%b r%b idx%0d d%0d o%b required=v0 r1 idx0 d0 o0",
               out_valid, in_ready, term_idx, out_data, out_ovf);
    end
    $display("reset: out_valid=%b in_ready=%b term_idx=%0d", out_valid, in_ready, term_idx);
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    bit seen = 0;
    bit ok;
    logic [OW:0] got, want;
    out_ready = 1'b1;
    send(16'sd100, 8'sd3);
    send(-16'sd50, 8'sd2);
    send(16'sd7, -8'sd8);
    send(16'sd1, 8'sd1);
    in_valid = 1'b0;
    for (int w = 0; w < 20 && !seen; w++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    checks++;
    if (!seen || cyc != acc_cyc + MUL) begin
      errors++;
      $display("FAIL basic_latency got=%0d required=%0d", cyc - acc_cyc, MUL);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse got=%b required=0", out_valid);
    end
    wait_results(1, ok);
    checks++;
    if (!ok || obs_q.size() != 1) begin
      errors++;
      $display("FAIL basic_count got=%0d required=1", obs_q.size());
    end else begin
      got = obs_q.pop_front();
      want = exp_q.pop_front();
      checks++;
      if (got !== want || got !== {1'b0, 24'd145}) begin
        errors++;
        $display("FAIL basic_data got=%0d/%b required=%0d/%b", got[OW-1:0], got[OW],
                 want[OW-1:0], want[OW]);
      end
      $display("basic: result data=%0d ovf=%b", got[OW-1:0], got[OW]);
    end
    obs_cyc_q.delete();
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [OW:0] got, want;
    obs_cyc_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < VL; i++) send(A_W'($urandom), B_W'($urandom));
    for (int i = 0; i < VL; i++) send(-16'sd32768, -8'sd128);
    in_valid = 1'b0;
    wait_results(2, ok);
    checks++;
    if (!ok || obs_q.size() != 2) begin
      errors++;
      $display("FAIL b2b_count got=%0d required=2", obs_q.size());
    end else begin
      checks++;
      if (obs_cyc_q[1] - obs_cyc_q[0] != VL) begin
        errors++;
        $display("FAIL b2b_spacing got=%0d required=%0d", obs_cyc_q[1] - obs_cyc_q[0], VL);
      end
      for (int i = 0; i < 2; i++) begin
        got = obs_q.pop_front();
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL b2b_data%0d got=%0d/%b required=%0d/%b", i, got[OW-1:0], got[OW],
                   want[OW-1:0], want[OW]);
        end
        $display("b2b: result %0d data=%h ovf=%b", i, got[OW-1:0], got[OW]);
      end
      checks++;
      if (got !== {1'b1, 24'h7FFFFF}) begin
        errors++;
        $display("FAIL b2b_saturate got=%h/%b required=7fffff/1", got[OW-1:0], got[OW]);
      end
    end
    obs_cyc_q.delete();
  endtask

  task automatic test_hold();
    bit seen = 0;
    bit ok;
    logic [OW-1:0] d0;
    logic [OW:0] got, want;
    out_ready = 1'b0;
    for (int i = 0; i < VL + 2; i++) send(A_W'($urandom_range(2000, 0)) - 16'sd1000, B_W'($urandom));
    in_valid = 1'b0;
    for (int w = 0; w < 20 && !seen; w++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    d0 = out_data;
    checks++;
    if (!seen || {out_ovf, d0} !== exp_q[0]) begin
      errors++;
      $display("FAIL hold_first got=%0d required=%0d", d0, exp_q[0][OW-1:0]);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== d0) begin
        errors++;
        $display("FAIL hold_stable cycle=%0d got=v%b r%b d%0d required=v1 r0 d%0d",
                 i, out_valid, in_ready, out_data, d0);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < VL - 2; i++) send(A_W'($urandom), B_W'($urandom));
    in_valid = 1'b0;
    wait_results(2, ok);
    checks++;
    if (!ok || obs_q.size() != 2) begin
      errors++;
      $display("FAIL hold_count got=%0d required=2", obs_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        got = obs_q.pop_front();
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL hold_data%0d got=%0d/%b required=%0d/%b", i, got[OW-1:0], got[OW],
                   want[OW-1:0], want[OW]);
        end
        $display("hold: result %0d data=%0d ovf=%b", i, got[OW-1:0], got[OW]);
      end
    end
  endtask

  task automatic test_random_gaps();
    bit ok;
    logic [OW:0] got, want;
    wraps = 0;
    out_ready = 1'b1;
    for (int t = 0; t < 8 * VL; t++) begin
      while ($urandom_range(1, 0) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send(A_W'($urandom), B_W'($urandom));
      checks++;
      if (term_idx !== 2'(exp_cnt)) begin
        errors++;
        $display("FAIL rand_term_idx got=%0d required=%0d", term_idx, exp_cnt);
      end
    end
    in_valid = 1'b0;
    wait_results(8, ok);
    checks++;
    if (!ok || obs_q.size() != 8) begin
      errors++;
      $display("FAIL rand_count got=%0d required=8", obs_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        got = obs_q.pop_front();
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL rand_data%0d got=%0d/%b required=%0d/%b", i, got[OW-1:0], got[OW],
                   want[OW-1:0], want[OW]);
        end
        $display("random: result %0d data=%0d ovf=%b", i, $signed(got[OW-1:0]), got[OW]);
      end
    end
    checks++;
    if (wraps != 8) begin
      errors++;
      $display("FAIL rand_wraps got=%0d required=8", wraps);
    end
  endtask

  task automatic test_reset_mid_vector();
    bit ok;
    logic [OW:0] got;
    out_ready = 1'b1;
    send(16'sd1, 8'sd1);
    send(16'sd1, 8'sd1);
    apply_reset();
    checks++;
    if (term_idx !== 2'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear got=idx%0d v%b required=idx0 v0", term_idx, out_valid);
    end
    for (int i = 0; i < VL; i++) send(16'sd1, 8'sd1);
    in_valid = 1'b0;
    wait_results(1, ok);
    checks++;
    if (!ok || obs_q.size() != 1) begin
      errors++;
      $display("FAIL midreset_count got=%0d required=1", obs_q.size());
    end else begin
      got = obs_q.pop_front();
      void'(exp_q.pop_front());
      checks++;
      if (got !== {1'b0, 24'd4}) begin
        errors++;
        $display("FAIL midreset_data got=%0d/%b required=4/0", got[OW-1:0], got[OW]);
      end
      $display("midreset: result data=%0d ovf=%b", got[OW-1:0], got[OW]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_hold();
    test_random_gaps();
    test_reset_mid_vector();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/compute_engine_mac_pipe.md
Name: compute_engine_mac_pipe

Overview:
- Parametrised signed multiply-accumulate engine; successor to the fixed 16s x 8s pipelined multiplier in the compute engines.
- Accepts a stream of (activation, weight) pairs over a valid/ready handshake and multiplies them in a configurable-depth pipeline.
- Accumulates every VEC_LEN products into one dot-product result.
- Emits the result saturated to OUT_W bits, with an overflow flag, on a registered valid/ready output.
- Sits between the weight/activation buffers and the layer output writer.

Parameters:
- A_W, 16: signed width of in_a.
- B_W, 8: signed width of in_b.
- MUL_STAGES, 3: register stages from input accept to product available; legal range 2..6.
- VEC_LEN, 16: products per dot product; legal range 2..1024.
- OUT_W, 24: signed output width; must be <= ACC_W.
- ACC_W, derived: A_W + B_W + clog2(VEC_LEN). Internal accumulator width. Not user-set.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- in_valid, input, 1: in_a/in_b hold a valid term.
- in_ready, output, 1: engine can accept a term this cycle.
- in_a, input, A_W: signed activation.
- in_b, input, B_W: signed weight.
- out_valid, output, 1: out_data/out_ovf hold a result.
- out_ready, input, 1: downstream consumes the result.
- out_data, output, OUT_W: saturated signed dot product.
- out_ovf, output, 1: out_data was saturated.
- term_idx, output, clog2(VEC_LEN): index of the next term to be accepted (debug/status).

Behaviour:
- Reset is synchronous on clk, active-high. At reset, all of the following clear to 0:
  - in_ready (reset cycle only), out_valid, out_data, out_ovf, term_idx;
  - the accumulator, all pipeline valid bits and all data registers.
- Reset mid-vector discards all partial sums and in-flight terms; no result is emitted for them.
- Advance enable: adv = !(out_valid && !out_ready). in_ready = adv (0 during reset). The pipeline, accumulator and term counter only move when adv=1. This is a global stall with no bubbles collapsed.
- Accept: a term is accepted on an edge with in_valid && in_ready. It enters stage 1 with a valid bit and a last bit. last=1 when term_idx == VEC_LEN-1.
- term_idx increments on each accept and wraps from VEC_LEN-1 to 0.
- Pipeline datapath:
  - stage 1 registers operands;
  - the full-precision signed product (A_W+B_W bits) is formed and carried through stages 2..MUL_STAGES;
  - valid/last bits travel alongside the data.
- Latency: a term accepted at edge k has its product at stage MUL_STAGES after edge k+MUL_STAGES-1, with no stalls. Each stall cycle adds one cycle.
- Accumulate: on an adv edge where stage MUL_STAGES holds a valid product:
  - first term of the vector: acc <= sign-extended product;
  - otherwise: acc <= acc + product, in ACC_W bits, which cannot overflow by construction.
- Emit: on that same edge, if the product's last bit is set:
  - out_data <= sat(acc_next);
  - out_ovf <= (acc_next outside [-2^(OUT_W-1), 2^(OUT_W-1)-1]);
  - out_valid <= 1;
  - the first-term flag re-arms for the next vector.
- The last term accepted at edge k produces out_valid high after edge k+MUL_STAGES (no stalls).
- Saturation clamps to +2^(OUT_W-1)-1 or -2^(OUT_W-1). Otherwise the value is truncated losslessly.
- Output hold: while out_valid && !out_ready, out_data/out_ovf are stable and in_ready=0.
- out_valid clears on an out_ready edge unless a new result is emitted on that same edge. In that case out_valid stays 1 with the new data, giving back-to-back results with no bubble.
- Gaps: in_valid low inserts bubbles. Bubbles do not touch the accumulator or term_idx.
- Throughput: one term per cycle sustained when out_ready=1.

Test Plan (VEC_LEN=4, MUL_STAGES=3, OUT_W=24 unless noted):
- Reset then idle: out_valid=0, in_ready=1 from the first post-reset cycle, term_idx=0.
- Stream (a,b) = (100,3), (-50,2), (7,-8), (1,1) back-to-back with out_ready=1:
  - out_data=145, out_ovf=0;
  - out_valid rises 3 cycles after the 4th accept and lasts 1 cycle.
- Two vectors back-to-back, second all (-32768,-128): second out_data=16777216 saturates to 8388607 with out_ovf=1. The first result is unaffected. No gap between results.
- Hold out_ready=0 when a result arrives:
  - in_ready drops to 0 and out_data stays constant for 5 cycles;
  - raising out_ready releases the result, and in-flight terms resume with no loss or duplication.
- Random in_valid gaps (50%) over 8 vectors compared against a reference model: every result matches, and term_idx wraps 3 to 0 exactly 8 times.
- Assert reset after 2 terms of a vector, then send a fresh full vector of all (1,1): out_data=4 (not 6), and exactly one result is produced.
